// File: rtl/async_fifo_pkg.sv
// Shared helpers for the async FIFO pointer crossings: Gray/binary conversion and bit counting.
// Functions work at PTR_MAX_W bits; narrower pointers are zero-extended on the way in and truncated on the way out.
package async_fifo_pkg;

  localparam int SYNC_STAGES_MIN = 2;
  localparam int PTR_MAX_W       = 64;

  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it; zero upper bits leave narrow pointers intact.
  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
    logic [PTR_MAX_W-1:0] b;
    b = g;
    for (int i = 1; i < PTR_MAX_W; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

  function automatic int unsigned popcount(input logic [PTR_MAX_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < PTR_MAX_W; i++) begin
      n = n + {31'd0, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Plain flop chain for clock-domain crossing; no logic between stages.
module sync_chain
  import async_fifo_pkg::*;
#(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (STAGES < SYNC_STAGES_MIN) begin : g_stages_chk
    $error("sync_chain: STAGES must be at least %0d", SYNC_STAGES_MIN);
  end

  logic [WIDTH-1:0] s [STAGES];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        s[i] <= '0;
      end
    end else begin
      s[0] <= d;
      for (int i = 1; i < STAGES; i++) begin
        s[i] <= s[i-1];
      end
    end
  end

  assign q = s[STAGES-1];

endmodule

// File: rtl/gray_ptr_sync.sv
// Gray pointer synchroniser: flop chain, registered binary decode, per-cycle advance and
// a sticky flag for illegal multi-bit Gray steps.
module gray_ptr_sync
  import async_fifo_pkg::*;
#(
  parameter int WIDTH     = 6,
  parameter int STAGES    = 2,
  parameter bit ERR_CHECK = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] gray_in,
  input  logic             err_clr,
  output logic [WIDTH-1:0] sync_gray_o,
  output logic [WIDTH-1:0] sync_bin_o,
  output logic [WIDTH-1:0] delta_o,
  output logic             changed_o,
  output logic             gray_err_o
);

  if (STAGES < SYNC_STAGES_MIN) begin : g_stages_chk
    $error("gray_ptr_sync: STAGES must be at least %0d", SYNC_STAGES_MIN);
  end
  if (WIDTH < 2 || WIDTH > PTR_MAX_W) begin : g_width_chk
    $error("gray_ptr_sync: WIDTH must be in 2..%0d", PTR_MAX_W);
  end

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] g_bin;
  logic             vld;
  logic             primed;
  logic             multi_bit;

  sync_chain #(.WIDTH(WIDTH), .STAGES(STAGES)) u_chain (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (gray_in),
    .q     (g)
  );

  // Marks when the chain holds a real post-reset sample rather than reset zeros,
  // so the first real pointer is absorbed without a spurious delta.
  sync_chain #(.WIDTH(1), .STAGES(STAGES)) u_vld (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (1'b1),
    .q     (vld)
  );

  assign g_bin     = WIDTH'(gray2bin(PTR_MAX_W'(g)));
  assign multi_bit = popcount(PTR_MAX_W'(g ^ sync_gray_o)) > 1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_gray_o <= '0;
      sync_bin_o  <= '0;
      delta_o     <= '0;
      changed_o   <= 1'b0;
      primed      <= 1'b0;
    end else begin
      sync_gray_o <= g;
      sync_bin_o  <= g_bin;
      if (primed) begin
        delta_o   <= g_bin - sync_bin_o;
        changed_o <= (g != sync_gray_o);
      end else begin
        delta_o   <= '0;
        changed_o <= 1'b0;
      end
      if (vld) begin
        primed <= 1'b1;
      end
    end
  end

  // A new error outranks a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gray_err_o <= 1'b0;
    end else if (ERR_CHECK && primed && multi_bit) begin
      gray_err_o <= 1'b1;
    end else if (err_clr) begin
      gray_err_o <= 1'b0;
    end
  end

endmodule
